// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding and the checksum helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int         INSTR_BYTES = 2;
  localparam logic [7:0] CSUM_INIT   = 8'h00;

  // Running frame checksum: plain XOR, no carry.
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Host byte-stream loader for instruction memory. Assembles 16-bit words,
// writes them from address 0 and releases cpu_hold once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  state_t             state_r, state_s;
  logic [7:0]         count_r, count_s;
  logic [ADDR_W-1:0]  idx_r, idx_s;
  logic [ADDR_W-1:0]  idx_inc_s;
  logic [7:0]         hi_r, hi_s;
  logic [7:0]         csum_r, csum_s;
  logic               we_r, we_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [INSTR_W-1:0] wdata_r, wdata_s;
  logic               hold_r, hold_s;
  logic               done_r, done_s;
  logic               error_r, error_s;
  logic               in_ready_s;
  logic               xfer_s;

  assign in_ready_s = (state_r == ST_COUNT) || (state_r == ST_HI) ||
                      (state_r == ST_LO)    || (state_r == ST_CHECK);
  assign xfer_s     = in_valid && in_ready_s;
  assign idx_inc_s  = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign in_ready   = in_ready_s;
  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign cpu_hold   = hold_r;
  assign done       = done_r;
  assign error      = error_r;

  // Next-state and next-datapath values for the load FSM.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    idx_s   = idx_r;
    hi_s    = hi_r;
    csum_s  = csum_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    hold_s  = hold_r;
    done_s  = done_r;
    error_s = error_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_s = ST_COUNT;
          done_s  = 1'b0;
          error_s = 1'b0;
          idx_s   = {ADDR_W{1'b0}};
          csum_s  = CSUM_INIT;
          hold_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_COUNT: begin
        if (xfer_s) begin
          count_s = in_data;
          csum_s  = in_data;
          if (in_data == 8'h00) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_HI;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_HI: begin
        if (xfer_s) begin
          hi_s    = in_data;
          csum_s  = csum_update(csum_r, in_data);
          state_s = ST_LO;
        end else begin
          state_s = state_r;
        end
      end
      ST_LO: begin
        if (xfer_s) begin
          csum_s  = csum_update(csum_r, in_data);
          wdata_s = INSTR_W'({hi_r, in_data});
          addr_s  = idx_r;
          we_s    = 1'b1;
          idx_s   = idx_inc_s;
          // N never exceeds 255, so the incremented index cannot wrap past it
          if (idx_inc_s == ADDR_W'(count_r)) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_HI;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CHECK: begin
        if (xfer_s) begin
          if (in_data == csum_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            hold_s  = 1'b0;
          end else begin
            state_s = ST_ERR;
            error_s = 1'b1;
            hold_s  = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        hold_s  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      count_r <= 8'h00;
      idx_r   <= {ADDR_W{1'b0}};
      hi_r    <= 8'h00;
      csum_r  <= CSUM_INIT;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {INSTR_W{1'b0}};
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      idx_r   <= idx_s;
      hi_r    <= hi_s;
      csum_r  <= csum_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      hold_r  <= hold_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// compared against a frame-level model of expected memory writes and status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] words[$];
  logic [7:0]  frame[$];
  bit          exp_done;
  int          wa[$];
  int          wd[$];
  int          wc[$];

  imem_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(int'(imem_wdata));
      wc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: COUNT, hi/lo bytes per word, XOR checksum optionally corrupted.
  task automatic make_frame(input logic [7:0] flip);
    logic [7:0] chk;
    frame.delete();
    chk = 8'(words.size());
    frame.push_back(chk);
    foreach (words[i]) begin
      frame.push_back(words[i][15:8]);
      frame.push_back(words[i][7:0]);
      chk = chk ^ words[i][15:8] ^ words[i][7:0];
    end
    frame.push_back(chk ^ flip);
    exp_done = (flip == 8'h00);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".start_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".start_done"}, 32'(done), 32'd0);
    check({tag, ".start_err"}, 32'(error), 32'd0);
    check({tag, ".start_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input bit rnd_gap);
    wa.delete(); wd.delete(); wc.delete();
    do_start(tag);
    foreach (frame[i]) send_byte(frame[i], rnd_gap ? int'($urandom_range(0, 3)) : 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input bit spacing);
    check({tag, ".nwrites"}, 32'(wa.size()), 32'(words.size()));
    for (int i = 0; i < wa.size() && i < words.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(wa[i]), 32'(i));
      check($sformatf("%s.data%0d", tag, i), 32'(wd[i]), 32'(words[i]));
      if (spacing && i > 0) check($sformatf("%s.gap%0d", tag, i), 32'(wc[i] - wc[i-1]), 32'd2);
    end
    if (words.size() > 0) begin
      check({tag, ".hold_addr"}, 32'(imem_addr), 32'(words.size() - 1));
      check({tag, ".hold_data"}, 32'(imem_wdata), 32'(words[words.size()-1]));
    end
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".error"}, 32'(error), 32'(!exp_done));
    check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.we", 32'(imem_we), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'd0);
    check("rst.wdata", 32'(imem_wdata), 32'd0);
    check("rst.hold", 32'(cpu_hold), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed frame: 02 12 34 AB CD 42, continuous valid.
    words.delete(); words.push_back(16'h1234); words.push_back(16'hABCD);
    make_frame(8'h00);
    send_frame("good", 1'b0);
    check_result("good", 1'b1);

    make_frame(8'h01);
    send_frame("badchk", 1'b0);
    check_result("badchk", 1'b1);

    make_frame(8'h00);
    send_frame("reload", 1'b0);
    check_result("reload", 1'b1);

    words.delete();
    make_frame(8'h00);
    send_frame("n0_good", 1'b0);
    check_result("n0_good", 1'b0);
    make_frame(8'h01);
    send_frame("n0_bad", 1'b0);
    check_result("n0_bad", 1'b0);

    // Random frames, first with random host gaps, then the same frame gap-free.
    for (int t = 0; t < 6; t++) begin
      rand_words(int'($urandom_range(1, 20)));
      make_frame(($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      send_frame($sformatf("rnd%0d_gap", t), 1'b1);
      check_result($sformatf("rnd%0d_gap", t), 1'b0);
      send_frame($sformatf("rnd%0d_flat", t), 1'b0);
      check_result($sformatf("rnd%0d_flat", t), 1'b1);
    end

    // start pulsed while in HI must be ignored.
    rand_words(4);
    make_frame(8'h00);
    wa.delete(); wd.delete(); wc.delete();
    do_start("hi_start");
    send_byte(frame[0], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < frame.size(); i++) send_byte(frame[i], 0);
    repeat (2) @(negedge clk);
    check_result("hi_start", 1'b1);

    // Largest frame: 255 words, last write at address 254.
    rand_words(255);
    make_frame(8'h00);
    send_frame("n255", 1'b0);
    check_result("n255", 1'b1);
    check("n255.last_addr", 32'(wa[wa.size()-1]), 32'd254);

    // Reset while waiting for the LO byte of the first word.
    wa.delete(); wd.delete(); wc.delete();
    do_start("rst_lo");
    send_byte(8'h03, 0);
    send_byte(8'h55, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_lo.in_ready", 32'(in_ready), 32'd0);
    check("rst_lo.we", 32'(imem_we), 32'd0);
    check("rst_lo.addr", 32'(imem_addr), 32'd0);
    check("rst_lo.hold", 32'(cpu_hold), 32'd1);
    check("rst_lo.done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_lo.idle_ready", 32'(in_ready), 32'd0);
    check("rst_lo.nwrites", 32'(wa.size()), 32'd0);

    rand_words(3);
    make_frame(8'h00);
    send_frame("after_rst", 1'b0);
    check_result("after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface that the fetch unit reads. It accepts a byte stream from a host over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into instruction memory from address 0. It holds the CPU core in reset (cpu_hold) until a complete program with a correct checksum has been loaded.

Parameters:
ADDR_W, 8, instruction-memory address width (matches the 8-bit PC)
INSTR_W, 16, instruction word width; fixed at 2 bytes per word

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  begin a load session; sampled in IDLE, DONE and ERR only
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_W  write address
imem_wdata  output  INSTR_W  write data
cpu_hold  output  1  high = keep CPU fetch/datapath in reset
done  output  1  program loaded and checksum good (level)
error  output  1  checksum mismatch (level)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low; reset low on a rising edge forces state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0. The internal count, word index, high-byte register and checksum all clear to 0. Reset asserted mid-load abandons the session; any words already written stay in memory but are not trusted.
- Frame format: COUNT byte N (number of words), then 2N payload bytes with the high byte first for each word, then a CHK byte. CHK must equal the XOR of the COUNT byte and all payload bytes.
- A byte transfers only on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered-free function of state: it is 1 in COUNT, HI, LO and CHECK, and 0 in IDLE, DONE and ERR.
- FSM states: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
  - IDLE/DONE/ERR with start=1: go to COUNT. On entry, clear done, error, word index and checksum, and set cpu_hold=1.
  - COUNT on a transfer: latch N and set csum=in_data. If N=0, go to CHECK; otherwise go to HI.
  - HI on a transfer: latch the high byte, csum ^= in_data, go to LO.
  - LO on a transfer: csum ^= in_data. Register imem_wdata={hi,in_data} and imem_addr=word index, pulse imem_we for exactly the next cycle, then increment the word index. If the incremented index equals N, go to CHECK; otherwise go to HI.
  - CHECK on a transfer: if in_data==csum, go to DONE with done=1 and cpu_hold=0. Otherwise go to ERR with error=1 and cpu_hold=1.
- start during COUNT, HI, LO or CHECK is ignored.
- Latency: imem_we is asserted the cycle after the LO byte transfers. With an always-valid host, back-to-back words produce a write strobe every 2 cycles.
- Width rules: the word index is ADDR_W bits. N<=255, so the index never wraps; the maximum address written is 254. The checksum is an 8-bit XOR with no carry.
- Host stalls (in_valid=0) hold the state indefinitely; there is no timeout.
- imem_addr and imem_wdata hold their last values between strobes.
- done and error are mutually exclusive. Both are levels that persist until start or reset.

Decomposition:
- Shared package: the state enum (IDLE, COUNT, HI, LO, CHECK, DONE, ERR, 3-bit encoding), INSTR_BYTES=2, and the constant CSUM_INIT=8'h00.
- No sub-module is needed. Byte assembly, the counter and the checksum fit in a single FSM-based module.

Test Plan:
- Reset while in LO mid-word → next cycle state IDLE, cpu_hold=1, in_ready=0, imem_we=0, done=0.
- start, then bytes 02,12,34,AB,CD, CHK=02^12^34^AB^CD=0x42, in_valid held high → writes addr0=0x1234 and addr1=0xABCD, one-cycle imem_we each, 2 cycles apart; done=1 and cpu_hold=0 the cycle after CHK.
- Same frame with CHK=0x43 → both words written, error=1, done=0, cpu_hold stays 1; a second start clears error and reloads cleanly.
- N=0: bytes 00, CHK=00 → no imem_we, done=1. Bytes 00, CHK=01 → error=1.
- Host inserts random in_valid gaps (e.g., 3 idle cycles between every byte) → identical memory contents and final status to the gap-free run; no extra imem_we pulses.
- start pulsed in HI state → ignored, load completes normally. N=255 with 510 payload bytes → last write at addr 254, done=1.
